sprite_renderer: RTL and testbench

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_pkg.sv | 11 +
 rtl/sprite_addr_gen.sv | 55 +++++
 rtl/sprite_renderer.sv | 132 +++++++++++++
 tb/tb_sprite_renderer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and screen/colour constants for the sprite renderer.
package sprite_pkg;
  localparam int RGB_W    = 16;
  localparam int SCREEN_W = 240;
  localparam int SCREEN_H = 320;
  localparam int X_W      = 8;
  localparam int Y_W      = 9;
  localparam int ID_W     = 4;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, FINISH} state_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// Raster row/col counters and sprite ROM address arithmetic.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int W      = 32,
  parameter int H      = 32,
  parameter int ADDR_W = 14,
  parameter int CW     = $clog2(W),
  parameter int RW     = $clog2(H)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [ID_W-1:0]   id,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_q == CW'(W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == CW'(W - 1)) && (row_q == RW'(H - 1));
  // ADDR_W is sized for the largest id, so nothing here can truncate.
  assign addr = ADDR_W'(id) * ADDR_W'(W * H) + ADDR_W'(row_q) * ADDR_W'(W) + ADDR_W'(col_q);
endmodule

// File: rtl/sprite_renderer.sv
// Sprite-to-LCD renderer: FETCH/WAIT/WRITE per pixel with screen clipping.
// Define TRANSPARENCY_EN to skip pixels whose colour equals TRANSPARENT_COLOUR.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int               SPRITE_WIDTH       = 32,
  parameter int               SPRITE_HEIGHT      = 32,
  parameter int               SCREEN_WIDTH       = SCREEN_W,
  parameter int               SCREEN_HEIGHT      = SCREEN_H,
  parameter logic [RGB_W-1:0] TRANSPARENT_COLOUR = 16'hF81F,
  parameter int               ADDR_W             = $clog2(16 * SPRITE_WIDTH * SPRITE_HEIGHT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    xSprite,
  input  logic [Y_W-1:0]    ySprite,
  input  logic [ID_W-1:0]   spriteId,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [RGB_W-1:0]  romData,
  output logic              pixelWrite,
  input  logic              pixelReady,
  output logic [X_W-1:0]    xPixel,
  output logic [Y_W-1:0]    yPixel,
  output logic [RGB_W-1:0]  pixelData,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(SPRITE_WIDTH);
  localparam int RW = $clog2(SPRITE_HEIGHT);
`ifdef TRANSPARENCY_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [X_W-1:0]     x0_q, x0_d, xpix_q, xpix_d;
  logic [Y_W-1:0]     y0_q, y0_d, ypix_q, ypix_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [RGB_W-1:0]   pdata_q, pdata_d;
  logic               busy_q, busy_d, done_q, done_d, pw_q, pw_d;
  logic               clr, adv, last, clipped, skip;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [X_W:0]       xs;
  logic [Y_W:0]       ys;

  sprite_addr_gen #(.W(SPRITE_WIDTH), .H(SPRITE_HEIGHT), .ADDR_W(ADDR_W)) u_addr (
    .clock(clock), .reset(reset), .clr(clr), .adv(adv), .id(id_q),
    .col(col), .row(row), .last(last), .addr(romAddr)
  );

  // One extra bit so a sprite hanging off the right/bottom edge cannot wrap back on screen.
  assign xs      = {1'b0, x0_q} + (X_W+1)'(col);
  assign ys      = {1'b0, y0_q} + (Y_W+1)'(row);
  assign clipped = (xs >= (X_W+1)'(SCREEN_WIDTH)) || (ys >= (Y_W+1)'(SCREEN_HEIGHT));
  assign skip    = clipped || (TRANSP_ON && (romData == TRANSPARENT_COLOUR));

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    id_d    = id_q;
    xpix_d  = xpix_q;
    ypix_d  = ypix_q;
    pdata_d = pdata_q;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        x0_d    = xSprite;
        y0_d    = ySprite;
        id_d    = spriteId;
        clr     = 1'b1;
        state_d = FETCH;
      end
      FETCH: state_d = WAIT;
      WAIT: if (skip) begin
        adv     = 1'b1;
        state_d = last ? FINISH : FETCH;
      end else begin
        xpix_d  = xs[X_W-1:0];
        ypix_d  = ys[Y_W-1:0];
        pdata_d = romData;
        state_d = WRITE;
      end
      WRITE: if (pixelReady) begin
        adv     = 1'b1;
        state_d = last ? FINISH : FETCH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FETCH) || (state_d == WAIT) || (state_d == WRITE);
    done_d = (state_d == FINISH);
    pw_d   = (state_d == WRITE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      id_q    <= '0;
      xpix_q  <= '0;
      ypix_q  <= '0;
      pdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      id_q    <= id_d;
      xpix_q  <= xpix_d;
      ypix_q  <= ypix_d;
      pdata_q <= pdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pw_q    <= pw_d;
    end
  end

  assign pixelWrite = pw_q;
  assign xPixel     = xpix_q;
  assign yPixel     = ypix_q;
  assign pixelData  = pdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a raster scoreboard model.
module tb_sprite_renderer;
  localparam int W = 32, H = 32, SW = 240, SH = 320;
`ifdef TRANSPARENCY_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, pixelReady = 1'b1;
  logic [7:0]  xSprite = '0;
  logic [8:0]  ySprite = '0;
  logic [3:0]  spriteId = '0;
  logic [13:0] romAddr;
  logic [15:0] romData = '0;
  logic        pixelWrite, busy, done;
  logic [7:0]  xPixel;
  logic [8:0]  yPixel;
  logic [15:0] pixelData;

  sprite_renderer dut (
    .clock(clock), .reset(reset), .start(start), .xSprite(xSprite), .ySprite(ySprite),
    .spriteId(spriteId), .romAddr(romAddr), .romData(romData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady), .xPixel(xPixel), .yPixel(yPixel), .pixelData(pixelData),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {int x; int y; int d;} px_t;
  px_t exp_q[$];
  px_t e_px;
  int checks = 0, fails = 0;
  int writes, done_cnt, max_x, first_x, first_y, first_d, last_x, last_y, last_d, seen_d;
  bit seen_t, hold_v;
  logic [7:0]  hx;
  logic [8:0]  hy;
  logic [15:0] hd;

  function automatic logic [15:0] rom_fn(input int a);
    if (a == 5 * W * H + 3) return 16'hF81F;
    return 16'(a) ^ 16'hA5A5;
  endfunction

  always @(posedge clock) romData <= rom_fn(int'(romAddr));

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every accepted write must be the next pixel the model expects.
  always @(negedge clock) begin
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v)
        chk(pixelWrite && xPixel == hx && yPixel == hy && pixelData == hd, "stall_hold",
            int'(pixelData), int'(hd));
      hold_v = 1'b0;
      if (pixelWrite) begin
        if (pixelReady) begin
          if (writes == 0) begin first_x = xPixel; first_y = yPixel; first_d = pixelData; end
          writes++;
          last_x = xPixel; last_y = yPixel; last_d = pixelData;
          if (int'(xPixel) > max_x) max_x = xPixel;
          if (xPixel == 8'd13 && yPixel == 9'd20) begin seen_t = 1'b1; seen_d = pixelData; end
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pixel unexpected write (%0d,%0d,%h)", xPixel, yPixel, pixelData);
          end else begin
            e_px = exp_q.pop_front();
            if (!(int'(xPixel) == e_px.x && int'(yPixel) == e_px.y && int'(pixelData) == e_px.d)) begin
              fails++;
              $display("FAIL pixel actual=(%0d,%0d,%h) required=(%0d,%0d,%h)",
                       xPixel, yPixel, pixelData, e_px.x, e_px.y, e_px.d);
            end
          end
        end else begin
          hold_v = 1'b1; hx = xPixel; hy = yPixel; hd = pixelData;
        end
      end
      if (done) begin
        done_cnt++;
        chk(!busy, "done_busy", int'(busy), 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk(!busy && !done && !pixelWrite, {tag, "_ctrl"}, int'({busy, done, pixelWrite}), 0);
    chk(romAddr == 14'd0, {tag, "_romaddr"}, int'(romAddr), 0);
    chk(xPixel == 8'd0 && yPixel == 9'd0, {tag, "_xy"}, int'(xPixel) + int'(yPixel), 0);
    chk(pixelData == 16'd0, {tag, "_data"}, int'(pixelData), 0);
  endtask

  // Model: raster walk of the sprite, dropping off-screen (and keyed) pixels.
  task automatic launch(input int x, input int y, input int id);
    int d;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        d = int'(rom_fn(id * W * H + r * W + c));
        if (x + c < SW && y + r < SH && !(TEN && d == 'hF81F)) exp_q.push_back('{x + c, y + r, d});
      end
    writes = 0; done_cnt = 0; max_x = -1; seen_t = 1'b0;
    xSprite = 8'(x); ySprite = 9'(y); spriteId = 4'(id); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk(busy, "busy_after_start", int'(busy), 1);
  endtask

  // Cycle 1 is the start cycle; returns the cycle index at which done is seen.
  task automatic end_frame(input string tag, output int n);
    bit got = 1'b0;
    n = 2;
    for (int i = 0; i < 6000; i++) begin
      if (done) begin got = 1'b1; break; end
      @(posedge clock); #1 n++;
    end
    chk(got, {tag, "_done_timeout"}, int'(got), 1);
    // A start arriving in the FINISH cycle must be dropped.
    spriteId = 4'd9; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk(!busy && !done, {tag, "_finish_start"}, int'({busy, done}), 0);
    @(posedge clock); #1;
    chk(!busy, {tag, "_idle_busy"}, int'(busy), 0);
    chk(done_cnt == 1, {tag, "_done_pulses"}, done_cnt, 1);
    chk(exp_q.size() == 0, {tag, "_missing"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    bit got;
    repeat (2) @(posedge clock);
    #1 check_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Frame on screen: 1024 writes, literal first/last pixels and latency.
    launch(95, 129, 2);
    chk(romAddr == 14'd2048, "a_first_romaddr", int'(romAddr), 2048);
    end_frame("a", n);
    chk(n == 3074, "a_latency", n, 3074);
    chk(writes == 1024, "a_writes", writes, 1024);
    chk(first_x == 95 && first_y == 129, "a_first_xy", first_x * 1000 + first_y, 95129);
    chk(first_d == 'hADA5, "a_first_data", first_d, 'hADA5);
    chk(last_x == 126 && last_y == 160, "a_last_xy", last_x * 1000 + last_y, 126160);
    chk(last_d == 'hAE5A, "a_last_data", last_d, 'hAE5A);

    // Right-edge clipping.
    launch(230, 10, 1);
    end_frame("b", n);
    chk(writes == 320, "b_writes", writes, 320);
    chk(max_x == 239, "b_max_x", max_x, 239);

    // Back-pressure on the first pixel.
    pixelReady = 1'b0;
    launch(0, 0, 3);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pixelWrite) begin got = 1'b1; break; end
      @(posedge clock); #1;
    end
    chk(got, "c_first_write_timeout", int'(got), 1);
    for (int k = 0; k < 5; k++) begin
      chk(pixelWrite && xPixel == 8'd0 && yPixel == 9'd0, "c_stall_xy", int'(xPixel), 0);
      chk(pixelData == 16'hA9A5, "c_stall_data", int'(pixelData), 'hA9A5);
      @(posedge clock); #1;
    end
    pixelReady = 1'b1;
    end_frame("c", n);
    chk(writes == 1024, "c_writes", writes, 1024);

    // Key colour at row 0 col 3 of sprite 5.
    launch(10, 20, 5);
    end_frame("d", n);
`ifdef TRANSPARENCY_EN
    chk(!seen_t, "d_keyed_skipped", int'(seen_t), 0);
    chk(writes == 1023, "d_writes", writes, 1023);
`else
    chk(seen_t && seen_d == 'hF81F, "d_keyed_written", seen_d, 'hF81F);
    chk(writes == 1024, "d_writes", writes, 1024);
`endif

    // Reset in the middle of a frame, then a clean full frame.
    launch(0, 0, 4);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #2;
      if (writes >= 500) break;
    end
    chk(writes == 500, "e_reached_500", writes, 500);
    #1 reset = 1'b1;
    #1 check_zero("e_async");
    exp_q.delete();
    @(posedge clock); #1;
    chk(!pixelWrite && !busy, "e_next_cycle", int'({pixelWrite, busy}), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    launch(0, 0, 4);
    end_frame("e2", n);
    chk(writes == 1024, "e2_writes", writes, 1024);
    chk(first_x == 0 && first_y == 0 && first_d == 'hB5A5, "e2_first", first_d, 'hB5A5);

    // Start while busy with another id must be ignored.
    launch(100, 50, 6);
    repeat (10) @(posedge clock);
    #1 spriteId = 4'd7; xSprite = 8'd0; ySprite = 9'd0; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    end_frame("f", n);
    chk(writes == 1024, "f_writes", writes, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
